memory_stage: RTL and testbench

Memory-access/write-back stage of the 8-bit MIPS pipeline, directly downstream of the execution block. Consumes the ALU result (`ans_ex`), store data (`DM_data`) and flags (`flag_ex`). Performs loads and stores against an internal synchronous data memory, latches architectural flags, and presents a registered write-back to the register file. Loads take an extra cycle, signalled upstream by `stall`.

---
 rtl/mips_defs.sv | 17 +
 rtl/data_memory.sv | 25 ++
 rtl/memory_stage.sv | 130 +++++++++++++
 tb/tb_memory_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared opcodes and memory-stage state encodings for the 8-bit MIPS pipeline
package mips_defs;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_LD  = 5'b10100;
    localparam logic [4:0] OP_ST  = 5'b10101;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LD_WAIT = 1'b1
    } mem_state_t;

    function automatic logic is_alu_op(input logic [4:0] op);
        return (op != OP_NOP) && (op != OP_LD) && (op != OP_ST);
    endfunction

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - single-port 2^ADDR_W x 8 synchronous RAM with one-cycle registered read
module data_memory #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    // Contents are deliberately not reset; a load returns whatever was last stored.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - memory/write-back stage; MEM_STAGE_STORE_FWD_EN adds a one-entry store-forwarding buffer
module memory_stage
    import mips_defs::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ans_ex,
    input  logic [7:0] DM_data,
    input  logic [3:0] flag_ex,
    input  logic [4:0] op_mem,
    input  logic [2:0] rd_mem,
    input  logic       valid_in,
    output logic       stall,
    output logic       wb_en,
    output logic [2:0] wb_rd,
    output logic [7:0] wb_data,
    output logic [3:0] flags
);

    mem_state_t        state;
    logic [2:0]        ld_rd;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        mem_rdata;
    logic              accept;
    logic              is_ld;
    logic              is_st;
    logic              mem_we;
    logic              mem_re;
    logic              fwd_hit;
    logic [7:0]        fwd_data;
    logic              unused_addr_hi;

    // Upper address bits are dropped so accesses wrap modulo the memory depth.
    assign addr           = ans_ex[ADDR_W-1:0];
    assign unused_addr_hi = ^ans_ex[7:ADDR_W];
    assign accept         = valid_in & ~stall & (state == ST_RUN);
    assign is_ld          = (op_mem == OP_LD);
    assign is_st          = (op_mem == OP_ST);
    assign mem_we         = accept & is_st;
    assign mem_re         = accept & is_ld & ~fwd_hit;

`ifdef MEM_STAGE_STORE_FWD_EN
    logic              sb_valid;
    logic [ADDR_W-1:0] sb_addr;
    logic [7:0]        sb_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_valid <= 1'b0;
        end else if (mem_we) begin
            sb_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            sb_addr <= addr;
            sb_data <= DM_data;
        end
    end

    assign fwd_hit  = sb_valid && (sb_addr == addr);
    assign fwd_data = sb_data;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = 8'h00;
`endif

    data_memory #(
        .ADDR_W (ADDR_W)
    ) u_data_memory (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr),
        .wdata (DM_data),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_RUN;
            stall   <= 1'b0;
            wb_en   <= 1'b0;
            wb_rd   <= 3'd0;
            wb_data <= 8'h00;
            flags   <= 4'h0;
            ld_rd   <= 3'd0;
        end else begin
            wb_en <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        if (is_ld) begin
                            if (fwd_hit) begin
                                wb_data <= fwd_data;
                                wb_rd   <= rd_mem;
                                wb_en   <= 1'b1;
                            end else begin
                                ld_rd <= rd_mem;
                                state <= ST_LD_WAIT;
                                stall <= 1'b1;
                            end
                        end else if (is_alu_op(op_mem)) begin
                            wb_data <= ans_ex;
                            wb_rd   <= rd_mem;
                            wb_en   <= 1'b1;
                            flags   <= flag_ex;
                        end
                    end
                end
                ST_LD_WAIT: begin
                    // RAM output was registered at the accepting edge; retire it now.
                    wb_data <= mem_rdata;
                    wb_rd   <= ld_rd;
                    wb_en   <= 1'b1;
                    state   <= ST_RUN;
                    stall   <= 1'b0;
                end
                default: begin
                    state <= ST_RUN;
                    stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage (transaction model plus literal timing checks)
module tb_memory_stage;

`ifdef MEM_STAGE_STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [4:0] T_NOP = 5'b00000;
    localparam logic [4:0] T_LD  = 5'b10100;
    localparam logic [4:0] T_ST  = 5'b10101;
    localparam logic [4:0] T_ALU = 5'b00001;

    typedef struct packed {
        logic [2:0] rd;
        logic [7:0] data;
    } wb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ans_ex = 8'h00;
    logic [7:0] DM_data = 8'h00;
    logic [3:0] flag_ex = 4'h0;
    logic [4:0] op_mem = 5'd0;
    logic [2:0] rd_mem = 3'd0;
    logic       valid_in = 1'b0;
    logic       stall;
    logic       wb_en;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic [3:0] flags;

    int   checks = 0;
    int   errors = 0;
    int   wb_count = 0;
    bit   chk_on = 1'b0;

    logic [7:0] m_mem [32];
    logic [3:0] m_flags = 4'h0;
    wb_t        exp_q[$];

    memory_stage #(.ADDR_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .ans_ex   (ans_ex),
        .DM_data  (DM_data),
        .flag_ex  (flag_ex),
        .op_mem   (op_mem),
        .rd_mem   (rd_mem),
        .valid_in (valid_in),
        .stall    (stall),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            wb_t e;
            checks++;
            if (flags !== m_flags) begin
                errors++;
                $display("FAIL flags actual=%b required=%b", flags, m_flags);
            end
            if (wb_en === 1'b1) begin
                wb_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wb actual=rd%0d/%h required=none", wb_rd, wb_data);
                end else begin
                    e = exp_q.pop_front();
                    if (wb_rd !== e.rd || wb_data !== e.data) begin
                        errors++;
                        $display("FAIL wb actual=rd%0d/%h required=rd%0d/%h", wb_rd, wb_data, e.rd, e.data);
                    end
                end
            end else if (wb_en !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL wb_en_x actual=%b required=0/1", wb_en);
            end
        end
    end

    // Present one instruction, hold it until accepted, then update the model.
    task automatic issue(input logic [4:0] op, input logic [7:0] ans, input logic [7:0] data,
                         input logic [3:0] fl, input logic [2:0] rd);
        bit done = 1'b0;
        @(negedge clk);
        op_mem = op; ans_ex = ans; DM_data = data; flag_ex = fl; rd_mem = rd; valid_in = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (stall === 1'b0) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        valid_in = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout actual=never required=accepted op=%b", op);
        end else begin
            case (op)
                T_LD:    exp_q.push_back('{rd: rd, data: m_mem[ans[4:0]]});
                T_ST:    m_mem[ans[4:0]] = data;
                T_NOP:   ;
                default: begin
                    exp_q.push_back('{rd: rd, data: ans});
                    m_flags = fl;
                end
            endcase
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c0;
        repeat (2) @(negedge clk);
        check("rst_stall", {7'd0, stall}, 8'h00);
        check("rst_wb_en", {7'd0, wb_en}, 8'h00);
        check("rst_wb_rd", {5'd0, wb_rd}, 8'h00);
        check("rst_wb_data", wb_data, 8'h00);
        check("rst_flags", {4'd0, flags}, 8'h00);
        reset = 1'b1;
        chk_on = 1'b1;

        // ALU op write-back and flag latch
        issue(T_ALU, 8'h7F, 8'h00, 4'b1010, 3'd5);
        @(negedge clk);
        check("alu_wb_en", {7'd0, wb_en}, 8'h01);
        check("alu_wb_data", wb_data, 8'h7F);
        check("alu_wb_rd", {5'd0, wb_rd}, 8'h05);
        check("alu_flags", {4'd0, flags}, 8'h0A);
        @(negedge clk);
        check("alu_pulse", {7'd0, wb_en}, 8'h00);

        // store then load of the same address
        issue(T_ST, 8'h03, 8'hA5, 4'b0101, 3'd0);
        issue(T_LD, 8'h03, 8'h00, 4'b0110, 3'd3);
        @(negedge clk);
        check("ld_n1_stall", {7'd0, stall}, FWD ? 8'h00 : 8'h01);
        check("ld_n1_wb_en", {7'd0, wb_en}, FWD ? 8'h01 : 8'h00);
        check("st_ld_flags", {4'd0, flags}, 8'h0A);
        @(negedge clk);
        check("ld_n2_stall", {7'd0, stall}, 8'h00);
        check("ld_n2_wb_en", {7'd0, wb_en}, FWD ? 8'h00 : 8'h01);
        check("ld_wb_data", wb_data, 8'hA5);
        check("ld_wb_rd", {5'd0, wb_rd}, 8'h03);

        // address wrap: 0x21 aliases 0x01
        issue(T_ST, 8'h21, 8'h3C, 4'h0, 3'd0);
        issue(T_LD, 8'h01, 8'h00, 4'h0, 3'd6);
        idle(3);
        check("wrap_wb_data", wb_data, 8'h3C);

        // ALU op held behind a stalling load
        c0 = wb_count;
        issue(T_LD, 8'h03, 8'h00, 4'h0, 3'd2);
        issue(T_ALU, 8'h42, 8'h00, 4'b0011, 3'd4);
        idle(4);
        check("hold_wb_pulses", 8'(wb_count - c0), 8'h02);
        check("hold_last_rd", {5'd0, wb_rd}, 8'h04);

        // NOP produces no write-back
        c0 = wb_count;
        issue(T_NOP, 8'hEE, 8'h00, 4'hF, 3'd7);
        idle(2);
        check("nop_no_wb", 8'(wb_count - c0), 8'h00);

        // reset in the middle of a load
        issue(T_LD, 8'h03, 8'h00, 4'h0, 3'd1);
        check("midld_stall", {7'd0, stall}, 8'h01);
        reset = 1'b0;
        exp_q.delete();
        m_flags = 4'h0;
        #1;
        check("midrst_stall", {7'd0, stall}, 8'h00);
        check("midrst_wb_en", {7'd0, wb_en}, 8'h00);
        check("midrst_wb_rd", {5'd0, wb_rd}, 8'h00);
        check("midrst_wb_data", wb_data, 8'h00);
        check("midrst_flags", {4'd0, flags}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // store buffer (if any) was cleared, memory kept its contents
        issue(T_LD, 8'h03, 8'h00, 4'h0, 3'd7);
        @(negedge clk);
        check("post_rst_ld_stall", {7'd0, stall}, 8'h01);
        issue(T_ALU, 8'h99, 8'h00, 4'b1111, 3'd1);
        idle(3);
        check("post_rst_alu_data", wb_data, 8'h99);
        check("queue_drained", 8'(exp_q.size()), 8'h00);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
